// File: rtl/sccb_pkg.sv
// sccb_pkg: shared SCCB target state encoding and bus constants
`timescale 1ns/1ps
package sccb_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_SUB,
        ST_WDATA,
        ST_RDATA,
        ST_RNA,
        ST_IGNORE
    } sccb_state_t;
    localparam int SCCB_BITS_PER_PHASE = 9;
    localparam logic [3:0] SCCB_LAST_BIT = 4'(SCCB_BITS_PER_PHASE - 1);
    localparam logic [7:0] SCCB_WR_ID = 8'h42;
    localparam logic [7:0] SCCB_RD_ID = 8'h43;
endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: 2-FF synchronizer plus history FF giving level and edge strobes
`timescale 1ns/1ps
module sccb_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic meta, sync, hist;
    // Idle bus is pulled high, so reset to 1 to avoid phantom edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            hist <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            hist <= sync;
        end
    end
    assign lvl  = sync;
    assign rise = sync & ~hist;
    assign fall = ~sync & hist;
endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder decoding 3-phase writes and 2-phase reads onto a register port
`timescale 1ns/1ps
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID = SCCB_WR_ID,
    parameter bit         ACK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_o,
    output logic       siod_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       id_err
);
    localparam logic [7:0] RD_ID = DEV_ID | 8'h01;
    sccb_state_t state, state_nxt;
    logic [3:0] bit_cnt;
    logic [7:0] rx, tx;
    logic sc_lvl, sc_rise, sc_fall, sd_lvl, sd_rise, sd_fall;
    logic start, stop, last, id_match, ack_slot;

    sccb_line_sync u_sioc (.clk(clk), .rst_n(rst_n), .line(sioc_i), .lvl(sc_lvl), .rise(sc_rise), .fall(sc_fall));
    sccb_line_sync u_siod (.clk(clk), .rst_n(rst_n), .line(siod_i), .lvl(sd_lvl), .rise(sd_rise), .fall(sd_fall));

    // A SIOC edge in the same sample wins: that is a bit edge, not a condition
    assign start    = sd_fall & sc_lvl & ~sc_rise;
    assign stop     = sd_rise & sc_lvl & ~sc_rise;
    assign last     = bit_cnt == SCCB_LAST_BIT;
    assign id_match = rx == DEV_ID || rx == RD_ID;
    assign ack_slot = ACK_EN && last &&
                      (state == ST_ID ? id_match : (state == ST_SUB || state == ST_WDATA));
    assign busy     = state != ST_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = ST_ID;
        else if (stop)
            state_nxt = ST_IDLE;
        else if (sc_rise) begin
            case (state)
                ST_ID:    if (last) state_nxt = rx == DEV_ID ? ST_SUB : rx == RD_ID ? ST_RDATA : ST_IGNORE;
                ST_SUB:   if (last) state_nxt = ST_WDATA;
                ST_WDATA: if (last) state_nxt = ST_IGNORE;
                ST_RDATA: if (bit_cnt == 4'd7) state_nxt = ST_RNA;
                ST_RNA:   state_nxt = ST_IGNORE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
            siod_o  <= 1'b1;
            siod_oe <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            id_err  <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            id_err <= 1'b0;
            if (start || stop) begin
                bit_cnt <= '0;
                siod_o  <= 1'b1;
                siod_oe <= 1'b0;
            end else begin
                if (sc_rise) begin
                    bit_cnt <= last ? 4'd0 : bit_cnt + 4'd1;
                    if (!last) rx <= {rx[6:0], sd_lvl};
                    if (last && state == ST_ID) begin
                        id_err <= !id_match;
                        tx     <= rd_data;
                    end
                    if (last && state == ST_SUB) wr_addr <= rx;
                    if (last && state == ST_WDATA) begin
                        wr_data <= rx;
                        wr_en   <= 1'b1;
                    end
                end
                // Drive changes only while SIOC is low so they never look like START/STOP
                if (sc_fall) begin
                    if (state == ST_RDATA) begin
                        siod_oe <= 1'b1;
                        siod_o  <= tx[7];
                        tx      <= {tx[6:0], 1'b0};
                    end else begin
                        siod_oe <= ack_slot;
                        siod_o  <= ~ack_slot;
                    end
                end
            end
        end
    end
endmodule
